bitsync_lock_ctrl: RTL

- Acquisition and lock controller that sits after the bit-synchroniser loop.
- Watches the bit-sync strobe and qualifies each strobe by its spacing; declares lock, and forces a loop restart through a reset request when lock is lost.
- Emits one decision-point symbol strobe per bit, delayed by a programmable offset from each qualified sync strobe.
- Downstream demod/framing logic consumes sym_data/sym_valid and the locked status.

---
 rtl/bitsync_pkg.sv | 9 +
 rtl/bitsync_lock_ctrl_meter.sv | 45 ++++
 rtl/bitsync_lock_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/bitsync_pkg.sv
// bitsync_pkg: shared state encoding, default constants and symbol type for the bit-sync lock controller
package bitsync_pkg;
    localparam int NOM_PERIOD_DEF = 32;
    localparam int TOL_DEF        = 2;
    localparam int SAMPLE_DLY_DEF = 11;
    localparam int DW_DEF         = 6;
    typedef logic signed [DW_DEF-1:0] sym_t;
    typedef enum logic [2:0] {IDLE, SEARCH, VERIFY, LOCKED, RESYNC} state_t;
endpackage

// File: rtl/bitsync_lock_ctrl_meter.sv
// sync_interval_meter: rising-edge detect, interval timer and GOOD/BAD/MISS classification as registered pulses
module sync_interval_meter import bitsync_pkg::*; #(
    parameter int NOM_PERIOD = NOM_PERIOD_DEF,
    parameter int TOL        = TOL_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic bit_sync_i,
    output logic good_o,
    output logic bad_o,
    output logic miss_o
);
    localparam int TW = $clog2(NOM_PERIOD + TOL + 2);
    localparam logic [TW-1:0] LO = TW'(NOM_PERIOD - TOL);
    localparam logic [TW-1:0] HI = TW'(NOM_PERIOD + TOL);
    localparam logic [TW-1:0] MX = TW'(NOM_PERIOD + TOL + 1);
    logic prev_q, good_q, bad_q, miss_q, rise, in_win, miss;
    logic [TW-1:0] tmr_q, tmr_d;
    // an edge at the miss threshold falls outside the window, so it counts as BAD and suppresses MISS
    always_comb begin
        rise   = bit_sync_i & ~prev_q;
        in_win = tmr_q >= LO && tmr_q <= HI;
        miss   = !rise && tmr_q == MX;
        tmr_d  = (rise || miss) ? TW'(1) : (&tmr_q) ? tmr_q : tmr_q + 1'b1;
    end
    // edge history, saturating timer and one-cycle event flags
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= 1'b0;
            tmr_q  <= '0;
            good_q <= 1'b0;
            bad_q  <= 1'b0;
            miss_q <= 1'b0;
        end else begin
            prev_q <= bit_sync_i;
            tmr_q  <= tmr_d;
            good_q <= rise && in_win;
            bad_q  <= rise && !in_win;
            miss_q <= miss;
        end
    end
    assign good_o = good_q;
    assign bad_o  = bad_q;
    assign miss_o = miss_q;
endmodule

// File: rtl/bitsync_lock_ctrl.sv
// bitsync_lock_ctrl: lock acquisition FSM, loop-reset request and delayed symbol sampling after the bit synchroniser
module bitsync_lock_ctrl import bitsync_pkg::*; #(
    parameter int NOM_PERIOD = NOM_PERIOD_DEF,
    parameter int TOL        = TOL_DEF,
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_CNT = 3,
    parameter int SAMPLE_DLY = SAMPLE_DLY_DEF,
    parameter int RST_CYC    = 4,
    parameter int DW         = DW_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 enable_i,
    input  logic                 bit_sync_i,
    input  logic signed [DW-1:0] datain_i,
    output logic signed [DW-1:0] sym_data_o,
    output logic                 sym_valid_o,
    output logic                 locked_o,
    output logic                 lock_lost_o,
    output logic                 bs_rst_o,
    output logic [7:0]           loss_cnt_o
);
    localparam int GW  = $clog2(LOCK_CNT + 1);
    localparam int MW  = $clog2(UNLOCK_CNT + 1);
    localparam int RW  = $clog2(RST_CYC + 1);
    localparam int DLW = $clog2(SAMPLE_DLY + 1);
    state_t state_q, state_d;
    logic good, bad, miss, err, fire, lost, lock_lost_q;
    logic [GW-1:0] good_cnt_q, good_cnt_d;
    logic [MW-1:0] miss_cnt_q, miss_cnt_d;
    logic [RW-1:0] rst_cnt_q, rst_cnt_d;
    logic [DLW-1:0] dly_cnt_q, dly_cnt_d;
    logic [7:0] loss_cnt_q;
    logic signed [DW-1:0] sym_q, sym_d;
    sync_interval_meter #(.NOM_PERIOD(NOM_PERIOD), .TOL(TOL)) u_meter (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .bit_sync_i (bit_sync_i),
        .good_o     (good),
        .bad_o      (bad),
        .miss_o     (miss)
    );
    assign err = bad | miss;
    // state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end
    // next-state logic; a low enable overrides every transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = SEARCH;
            SEARCH:  if (good || bad) state_d = VERIFY;
            VERIFY:  if (good && good_cnt_q == GW'(LOCK_CNT - 1)) state_d = LOCKED;
                     else if (err) state_d = SEARCH;
            LOCKED:  if (err && miss_cnt_q == MW'(UNLOCK_CNT - 1)) state_d = RESYNC;
            RESYNC:  if (rst_cnt_q == RW'(RST_CYC - 1)) state_d = SEARCH;
            default: state_d = IDLE;
        endcase
        if (!enable_i) state_d = IDLE;
    end
    // counters and sample scheduler; a GOOD edge reloads the delay and drops any older pending sample
    always_comb begin
        fire       = state_q == LOCKED && enable_i && !good && dly_cnt_q == DLW'(1);
        lost       = state_q == LOCKED && state_d == RESYNC;
        good_cnt_d = state_q != VERIFY ? '0 : good ? good_cnt_q + 1'b1 : err ? '0 : good_cnt_q;
        miss_cnt_d = state_q != LOCKED ? '0 : good ? '0 : err ? miss_cnt_q + 1'b1 : miss_cnt_q;
        rst_cnt_d  = state_q == RESYNC ? rst_cnt_q + 1'b1 : '0;
        dly_cnt_d  = (state_q != LOCKED || !enable_i) ? '0 : good ? DLW'(SAMPLE_DLY) : dly_cnt_q != '0 ? dly_cnt_q - 1'b1 : '0;
        sym_d      = fire ? datain_i : sym_q;
    end
    // datapath registers; loss count saturates at 255 and survives enable going low
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            good_cnt_q  <= '0;
            miss_cnt_q  <= '0;
            rst_cnt_q   <= '0;
            dly_cnt_q   <= '0;
            sym_q       <= '0;
            lock_lost_q <= 1'b0;
            loss_cnt_q  <= '0;
        end else begin
            good_cnt_q  <= good_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            rst_cnt_q   <= rst_cnt_d;
            dly_cnt_q   <= dly_cnt_d;
            sym_q       <= sym_d;
            lock_lost_q <= lost;
            loss_cnt_q  <= loss_cnt_q + {7'd0, lost && loss_cnt_q != 8'hFF};
        end
    end
    // outputs; the strobe cycle presents the live datain so sym_data matches the captured value
    always_comb begin
        locked_o    = state_q == LOCKED;
        bs_rst_o    = state_q == RESYNC;
        sym_valid_o = fire;
        sym_data_o  = fire ? datain_i : sym_q;
        lock_lost_o = lock_lost_q;
        loss_cnt_o  = loss_cnt_q;
    end
endmodule
